// File: rtl/ex_if.sv
// ID/EX-to-EX/MEM bundle for the execute stage: pipeline-register fields in,
// execute results out.
interface ex_if;
    logic        stall_in;
    logic [4:0]  opcode;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] sign_ext_imm;
    logic [31:0] pc_plus_4;
    logic        interrupt;
    logic        cmp;
    logic        returni;
    logic        call;
    logic        mem_addr_sel;
    logic [1:0]  sp_sel;
    logic        mem_wr;
    logic        mem_rd;
    logic        reg_wr;
    logic [31:0] alu_result;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr_g;
    logic        mem_rd_g;
    logic        reg_wr_g;
    logic [3:0]  flags;
    logic [31:0] sp_out;
    logic        ex_busy;

    modport master (
        output stall_in, opcode, rd1, rd2, sign_ext_imm, pc_plus_4,
               interrupt, cmp, returni, call, mem_addr_sel, sp_sel,
               mem_wr, mem_rd, reg_wr,
        input  alu_result, mem_addr, mem_wdata, mem_wr_g, mem_rd_g,
               reg_wr_g, flags, sp_out, ex_busy
    );

    modport slave (
        input  stall_in, opcode, rd1, rd2, sign_ext_imm, pc_plus_4,
               interrupt, cmp, returni, call, mem_addr_sel, sp_sel,
               mem_wr, mem_rd, reg_wr,
        output alu_result, mem_addr, mem_wdata, mem_wr_g, mem_rd_g,
               reg_wr_g, flags, sp_out, ex_busy
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU/address/store-data path, stack pointer,
// condition flags with interrupt save/restore, and a 32-step shift-add multiplier.
module ex_stage #(
    parameter logic [31:0] SP_INIT = 32'h0000_FFFC
) (
    input  logic clk,
    input  logic rst_n,
    ex_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} mul_state_t;

    mul_state_t  state_reg, state_next;
    logic [31:0] mcand_reg, mcand_next;
    logic [31:0] mplier_reg, mplier_next;
    logic [31:0] acc_reg, acc_next;
    logic [5:0]  count_reg, count_next;
    logic [31:0] sp_reg;
    logic [3:0]  flags_reg;
    logic [3:0]  saved_flags_reg;

    logic        is_mul;
    logic        busy;
    logic        advance;
    logic        use_imm;
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic [32:0] diff;
    logic [3:0]  cmp_flags;

    assign is_mul  = (bus.opcode == 5'd13);
    assign advance = !bus.stall_in && !busy;
    assign use_imm = (bus.opcode >= 5'd9 && bus.opcode <= 5'd12) || (bus.opcode >= 5'd14);
    assign op_b    = use_imm ? bus.sign_ext_imm : bus.rd2;
    assign shamt   = op_b[4:0];

    // rd1 - rd2 as rd1 + ~rd2 + 1 so bit 32 is the no-borrow carry
    assign diff      = {1'b0, bus.rd1} + {1'b0, ~bus.rd2} + 33'd1;
    assign cmp_flags = {diff[31],
                        (diff[31:0] == 32'd0),
                        diff[32],
                        (bus.rd1[31] != bus.rd2[31]) && (diff[31] != bus.rd1[31])};

    always_comb begin
        bus.alu_result = 32'd0;
        case (bus.opcode)
            5'd0:    bus.alu_result = 32'd0;
            5'd1:    bus.alu_result = bus.rd1 + op_b;
            5'd2:    bus.alu_result = bus.rd1 - op_b;
            5'd3:    bus.alu_result = bus.rd1 & op_b;
            5'd4:    bus.alu_result = bus.rd1 | op_b;
            5'd5:    bus.alu_result = bus.rd1 ^ op_b;
            5'd6:    bus.alu_result = bus.rd1 << shamt;
            5'd7:    bus.alu_result = bus.rd1 >> shamt;
            5'd8:    bus.alu_result = $unsigned($signed(bus.rd1) >>> shamt);
            5'd9:    bus.alu_result = bus.rd1 + op_b;
            5'd10:   bus.alu_result = bus.rd1 & op_b;
            5'd11:   bus.alu_result = bus.rd1 | op_b;
            5'd12:   bus.alu_result = op_b << 16;
            5'd13:   bus.alu_result = acc_reg;
            default: bus.alu_result = bus.rd1 + op_b;
        endcase
    end

    always_comb begin
        if (!bus.mem_addr_sel)
            bus.mem_addr = bus.rd1 + bus.sign_ext_imm;
        else if (bus.sp_sel == 2'b01)
            bus.mem_addr = sp_reg - 32'd4;
        else
            bus.mem_addr = sp_reg;
    end

    assign bus.mem_wdata = (bus.call || bus.interrupt) ? bus.pc_plus_4 : bus.rd2;
    assign bus.mem_wr_g  = bus.mem_wr && !busy;
    assign bus.mem_rd_g  = bus.mem_rd && !busy;
    assign bus.reg_wr_g  = bus.reg_wr && !busy;
    assign bus.flags     = flags_reg;
    assign bus.sp_out    = sp_reg;
    assign bus.ex_busy   = busy;

    always_comb begin
        state_next  = state_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        acc_next    = acc_reg;
        count_next  = count_reg;
        busy        = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (is_mul) begin
                    busy        = 1'b1;
                    mcand_next  = bus.rd1;
                    mplier_next = bus.rd2;
                    acc_next    = 32'd0;
                    count_next  = 6'd0;
                    state_next  = S_BUSY;
                end
            end
            S_BUSY: begin
                // A MUL that vanished from EX was flushed; abandon the product.
                if (!is_mul) begin
                    state_next = S_IDLE;
                end else begin
                    busy = 1'b1;
                    if (mplier_reg[0])
                        acc_next = acc_reg + mcand_reg;
                    mcand_next  = mcand_reg << 1;
                    mplier_next = mplier_reg >> 1;
                    count_next  = count_reg + 6'd1;
                    if (count_reg == 6'd31)
                        state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            mcand_reg  <= 32'd0;
            mplier_reg <= 32'd0;
            acc_reg    <= 32'd0;
            count_reg  <= 6'd0;
        end else begin
            state_reg  <= state_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            acc_reg    <= acc_next;
            count_reg  <= count_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_reg          <= SP_INIT;
            flags_reg       <= 4'd0;
            saved_flags_reg <= 4'd0;
        end else if (advance) begin
            case (bus.sp_sel)
                2'b01:   sp_reg <= sp_reg - 32'd4;
                2'b10:   sp_reg <= sp_reg + 32'd4;
                default: sp_reg <= sp_reg;
            endcase
            if (bus.returni)
                flags_reg <= saved_flags_reg;
            else if (bus.cmp)
                flags_reg <= cmp_flags;
            if (bus.interrupt)
                saved_flags_reg <= flags_reg;
        end
    end
endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage CPU pipeline. It consumes the outputs of the ID/EX pipeline register and produces the ALU result, memory address and store data for the EX/MEM register. It owns three pieces of architectural state: the stack pointer, the condition flags, and the flags saved on interrupt entry. It also runs an iterative 32-cycle multiplier that stalls the front of the pipe.

## Interface
- SP_INIT, 32'h0000_FFFC, stack pointer value after reset
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- stall_in  in  1  hazard-unit stall; same signal drives the ID/EX stall, and while high the instruction in EX does not advance
- opcode  in  5  ALU operation
- rd1, rd2  in  32  bypassed register operands
- sign_ext_imm  in  32  immediate
- pc_plus_4  in  32  return address
- interrupt, cmp, returni, call, mem_addr_sel  in  1  control bits from ID/EX
- sp_sel  in  2  00 none, 01 push, 10 pop, 11 reserved
- mem_wr, mem_rd, reg_wr  in  1  control bits to be gated
- alu_result  out  32  execute result
- mem_addr  out  32  data-memory address
- mem_wdata  out  32  store data
- mem_wr_g, mem_rd_g, reg_wr_g  out  1  the matching input ANDed with !ex_busy
- flags  out  4  {N,Z,C,V}
- sp_out  out  32  current stack pointer
- ex_busy  out  1  multiplier busy; ORed into the hazard-unit stall

## Operation
- **Opcode map.** Operand B is rd2 for codes 1–8 and 13, and sign_ext_imm for codes 9–12 and 14–31.
  - 0 NOP gives result 0.
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR.
  - 6 SLL, 7 SRL, 8 SRA: shift amount is B[4:0].
  - 9 ADDI, 10 ANDI, 11 ORI.
  - 12 LUI gives imm<<16.
  - 13 MUL gives the low 32 bits of rd1*rd2.
  - 14–31 give rd1+imm.
  - All arithmetic is mod 2^32.
- **Memory address.**
  - mem_addr_sel=0: mem_addr = rd1+sign_ext_imm.
  - mem_addr_sel=1, push: mem_addr = sp−4.
  - mem_addr_sel=1, pop or reserved: mem_addr = sp.
- **Store data.** mem_wdata = pc_plus_4 when call or interrupt is set, else rd2.
- **Advance.** "Advance" means !stall_in && !ex_busy. SP, flags and saved flags change only on an advancing edge.
- **Stack pointer.**
  - Push: sp ← sp−4.
  - Pop: sp ← sp+4.
  - 00 and 11: hold. Wraps mod 2^32.
- **Flags.** On cmp, flags ← result of rd1−rd2 computed as rd1+~rd2+1:
  - N = bit31.
  - Z = (diff==0).
  - C = carry-out, so 1 when rd1≥rd2 unsigned.
  - V = signed overflow.
- **Interrupt save/restore.**
  - interrupt: saved_flags ← flags.
  - returni: flags ← saved_flags.
  - returni has priority over cmp when both are set.
- **Multiplier FSM.**
  - IDLE: if opcode==13, assert ex_busy, load multiplicand=rd1, multiplier=rd2, acc=0, count=0, and go to BUSY.
  - BUSY: ex_busy=1. Each edge: if multiplier[0], acc += multiplicand; then multiplicand <<= 1, multiplier >>= 1, count++. After the step with count reaching 32, go to DONE.
  - BUSY with opcode≠13 (the instruction was flushed): abort to IDLE immediately, ex_busy combinationally 0.
  - DONE: ex_busy=0, alu_result=acc, go to IDLE. A MUL that follows back-to-back restarts from IDLE.
- **Gating.** While ex_busy=1, mem_wr_g, mem_rd_g and reg_wr_g are 0.

## Timing
- All outputs except sp_out, flags and FSM-derived ex_busy are combinational from the inputs and the current state.
- **Reset values.**
  - sp_out = SP_INIT.
  - flags = 0 and saved_flags = 0.
  - FSM = IDLE, ex_busy = 0.
  - With the all-zero ID/EX reset contents: alu_result=0, mem_addr=0, mem_wdata=0, gated strobes 0.
- **Reset mid-multiply.** Returns the FSM to IDLE and drops ex_busy asynchronously.
- **Non-MUL ops.** Zero-cycle latency; results are valid in the cycle the instruction sits in EX.
- **MUL ops.**
  - The MUL enters EX in cycle 0.
  - ex_busy is high in cycles 0–32.
  - The product appears on alu_result in cycle 33, with ex_busy=0.
  - The instruction advances at the end of cycle 33, provided stall_in=0.
- **stall_in during DONE.** The FSM still returns to IDLE. A MUL still present in EX would restart, so the hazard unit never stalls EX on a MUL in DONE.
- **Push/pop under stall.** A push or pop held several cycles by stall_in updates sp exactly once, on its advancing edge.

## Test plan
- Reset with SP_INIT default → sp_out=32'h0000_FFFC, flags=0, ex_busy=0, alu_result=0.
- Run SUB, SRA and LUI, and ADD overflow:
  - SUB rd1=5, rd2=7 → 32'hFFFF_FFFE.
  - SRA rd1=32'h8000_0000, rd2=4 → 32'hF800_0000.
  - LUI imm=32'h1234 → 32'h1234_0000.
  - ADD of 32'hFFFF_FFFF and 1 → 0.
- Run CMP, then an interrupt, a second CMP and a returni:
  - CMP rd1=3, rd2=3 → flags 4'b0110.
  - Then interrupt, then CMP 1 vs 2 → flags 4'b1000.
  - Then returni → flags 4'b0110.
- Run MUL rd1=32'h0001_0003, rd2=32'h0000_0005 → ex_busy high 33 cycles, mem_wr_g=0 throughout, alu_result=32'h0005_000F in cycle 33. Repeat back-to-back: the second MUL also takes 33 busy cycles.
- Flush a MUL: opcode forced to 0 in cycle 10 → ex_busy drops that cycle, FSM IDLE, and the next ADD completes in zero cycles.
- Run push/call and pop:
  - call push with stall_in high 3 cycles, pc_plus_4=32'h40 → mem_addr=32'hFFF8, mem_wdata=32'h40, sp_out=32'hFFF8 after one advance only.
  - Then pop → mem_addr=32'hFFF8, sp_out=32'hFFFC.
